// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } sel_t;

    localparam int WORD_BYTES = 4;
    localparam int PC_W       = 32;

endpackage

// File: rtl/jump_target_gen.sv
// Combinational jump/branch target arithmetic, both relative to pc_plus4.
module jump_target_gen
    import pc_seq_pkg::*;
(
    input  logic [PC_W-1:0] pc_plus4,
    input  logic [25:0]     jump_index,
    input  logic [15:0]     branch_offset,
    output logic [PC_W-1:0] j_target,
    output logic [PC_W-1:0] br_target
);

    logic signed [PC_W-1:0] w_off_bytes;

    // Word offset scaled to bytes; the add wraps modulo 2^32 by construction.
    assign w_off_bytes = {{14{branch_offset[15]}}, branch_offset, 2'b00};
    assign br_target   = pc_plus4 + $unsigned(w_off_bytes);
    assign j_target    = {pc_plus4[31:28], jump_index, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: BOOT -> FETCH -> EXEC loop, HALTED terminal.
// Optional redirect counter output enabled by macro REDIRECT_CNT_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int              MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            instr_valid,
    input  logic            branch_taken,
    input  logic [15:0]     branch_offset,
    input  logic            jump,
    input  logic [25:0]     jump_index,
    input  logic            jr,
    input  logic [PC_W-1:0] jr_target,
    input  logic            halt,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            halted,
    output logic            misalign_err,
`ifdef REDIRECT_CNT_EN
    output logic [15:0]     redirect_cnt,
`endif
    output logic            fetch_timeout
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t          r_state, w_state_nxt;
    sel_t            w_sel;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [7:0]      r_wait, w_wait_nxt;
    logic            r_misalign, w_misalign_nxt;
    logic            r_timeout, w_timeout_nxt;
    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_j_target;
    logic [PC_W-1:0] w_br_target;

    assign w_pc_plus4 = r_pc + PC_W'(WORD_BYTES);

    jump_target_gen u_tgt (
        .pc_plus4      (w_pc_plus4),
        .jump_index    (jump_index),
        .branch_offset (branch_offset),
        .j_target      (w_j_target),
        .br_target     (w_br_target)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_wait     <= 8'd0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_wait     <= w_wait_nxt;
            r_misalign <= w_misalign_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_nxt     = r_wait;
        w_misalign_nxt = r_misalign;
        w_timeout_nxt  = r_timeout;
        w_sel          = SEL_SEQ;
        case (r_state)
            BOOT: w_state_nxt = FETCH;
            FETCH: begin
                // An ack on the last permitted wait cycle still completes the fetch.
                if (imem_ack) begin
                    w_state_nxt = EXEC;
                    w_wait_nxt  = 8'd0;
                end else if (r_wait >= WAIT_LAST) begin
                    w_state_nxt   = HALTED;
                    w_timeout_nxt = 1'b1;
                    w_wait_nxt    = r_wait + 8'd1;
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end
            EXEC: begin
                if (halt) begin
                    w_state_nxt = HALTED;
                end else if (jr) begin
                    if (jr_target[1:0] != 2'b00) begin
                        w_state_nxt    = HALTED;
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_state_nxt = FETCH;
                        w_sel       = SEL_JR;
                    end
                end else if (jump) begin
                    w_state_nxt = FETCH;
                    w_sel       = SEL_J;
                end else if (branch_taken) begin
                    w_state_nxt = FETCH;
                    w_sel       = SEL_BR;
                end else begin
                    w_state_nxt = FETCH;
                end
            end
            HALTED: w_state_nxt = HALTED;
            default: w_state_nxt = BOOT;
        endcase
    end

    // PC only moves when EXEC hands control back to FETCH.
    always_comb begin
        w_pc_nxt = r_pc;
        if (r_state == EXEC && w_state_nxt == FETCH) begin
            case (w_sel)
                SEL_BR:  w_pc_nxt = w_br_target;
                SEL_J:   w_pc_nxt = w_j_target;
                SEL_JR:  w_pc_nxt = jr_target;
                default: w_pc_nxt = w_pc_plus4;
            endcase
        end
    end

    assign imem_req      = (r_state == FETCH);
    assign imem_addr     = imem_req ? r_pc : '0;
    assign instr_valid   = (r_state == EXEC);
    assign halted        = (r_state == HALTED);
    assign pc            = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign misalign_err  = r_misalign;
    assign fetch_timeout = r_timeout;

`ifdef REDIRECT_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] r_redirect_cnt;
    logic        w_redirect;

    // Counts every applied redirect, even one whose target happens to equal pc_plus4.
    assign w_redirect = (r_state == EXEC) && (w_state_nxt == FETCH) && (w_sel != SEL_SEQ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_redirect_cnt <= 16'd0;
        end else if (w_redirect) begin
            r_redirect_cnt <= sat_inc16(r_redirect_cnt);
        end
    end

    assign redirect_cnt = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, corner sequences, random slots vs model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic        instr_valid;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_offset = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = '0;
    logic        halt = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        misalign_err;
    logic        fetch_timeout;
`ifdef REDIRECT_CNT_EN
    logic [15:0] redirect_cnt;
`endif

    pc_sequencer #(.RESET_PC(32'h0000_0000), .MAX_WAIT(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .instr_valid   (instr_valid),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_target     (jr_target),
        .halt          (halt),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .halted        (halted),
        .misalign_err  (misalign_err),
`ifdef REDIRECT_CNT_EN
        .redirect_cnt  (redirect_cnt),
`endif
        .fetch_timeout (fetch_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          delay;
        bit          br;
        logic [15:0] off;
        bit          j;
        logic [25:0] idx;
        bit          jr;
        logic [31:0] jt;
        bit          h;
        logic [31:0] exp_pc;
        bit          exp_halt;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_mis;
    int          m_cnt;
    int          prev_exec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int d, input bit br, input logic [15:0] off, input bit j,
                                input logic [25:0] idx, input bit jrr, input logic [31:0] jt,
                                input bit h, input logic [31:0] epc, input bit eh);
        vec_t v;
        v.delay = d; v.br = br; v.off = off; v.j = j; v.idx = idx;
        v.jr = jrr; v.jt = jt; v.h = h; v.exp_pc = epc; v.exp_halt = eh;
        return v;
    endfunction

    // Reference: what the next PC must be after a decode slot, from the architectural rules.
    task automatic model_step(input vec_t v);
        logic [31:0] np;
        int          so;
        np = m_pc + 32'd4;
        if (v.h) begin
            m_halt = 1'b1;
        end else if (v.jr) begin
            if (v.jt % 4 != 0) begin
                m_mis  = 1'b1;
                m_halt = 1'b1;
            end else begin
                m_pc = v.jt;
                if (m_cnt < 65535) m_cnt++;
            end
        end else if (v.j) begin
            m_pc = (np & 32'hF000_0000) + ({6'd0, v.idx} * 32'd4);
            if (m_cnt < 65535) m_cnt++;
        end else if (v.br) begin
            so   = $signed(v.off);
            m_pc = np + 32'(so * 4);
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_pc = np;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        chk("rst_timeout", {31'd0, fetch_timeout}, 32'd0);
        chk("rst_pc", pc, 32'd0);
`ifdef REDIRECT_CNT_EN
        chk("rst_redirect_cnt", {16'd0, redirect_cnt}, 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("boot_one_cycle", {31'd0, imem_req}, 32'd1);
        m_pc = 32'd0; m_halt = 1'b0; m_mis = 1'b0; m_cnt = 0; prev_exec = -1;
    endtask

    task automatic run_slot(input vec_t v);
        int w;
        w = 0;
        while (!imem_req && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, m_pc);
        chk("fetch_pc", pc, m_pc);
        for (int d = 0; d < v.delay; d++) begin
            imem_ack = 1'b0;
            @(posedge clk); #1;
            chk("wait_req_held", {31'd0, imem_req}, 32'd1);
        end
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("exec_valid", {31'd0, instr_valid}, 32'd1);
        chk("exec_req_low", {31'd0, imem_req}, 32'd0);
        chk("exec_addr_zero", imem_addr, 32'd0);
        chk("exec_pc_plus4", pc_plus4, m_pc + 32'd4);
        if (prev_exec >= 0) chk("slot_period", 32'(cyc - prev_exec), 32'(2 + v.delay));
        prev_exec = cyc;
        branch_taken = v.br; branch_offset = v.off; jump = v.j; jump_index = v.idx;
        jr = v.jr; jr_target = v.jt; halt = v.h;
        model_step(v);
        @(posedge clk); #1;
        branch_taken = 1'b0; jump = 1'b0; jr = 1'b0; halt = 1'b0;
        branch_offset = $urandom; jump_index = $urandom; jr_target = $urandom;
        chk("post_pc", pc, m_pc);
        chk("post_halted", {31'd0, halted}, {31'd0, m_halt});
        chk("post_misalign", {31'd0, misalign_err}, {31'd0, m_mis});
        chk("post_valid_low", {31'd0, instr_valid}, 32'd0);
`ifdef REDIRECT_CNT_EN
        chk("redirect_cnt", {16'd0, redirect_cnt}, 32'(m_cnt));
`endif
        if (m_halt) prev_exec = -1;
    endtask

    vec_t tbl[13];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vec_t v;
        tbl[0]  = mk(0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,         0, 32'h0000_0004, 0);
        tbl[1]  = mk(0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,         0, 32'h0000_0008, 0);
        tbl[2]  = mk(0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,         0, 32'h0000_000C, 0);
        tbl[3]  = mk(1, 0, 16'h0000, 0, 26'h0,       1, 32'h4000_0010, 0, 32'h4000_0010, 0);
        tbl[4]  = mk(0, 0, 16'h0000, 1, 26'h0000100, 0, 32'h0,         0, 32'h4000_0400, 0);
        tbl[5]  = mk(2, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_0100, 0, 32'h0000_0100, 0);
        tbl[6]  = mk(0, 1, 16'hFFFE, 0, 26'h0,       0, 32'h0,         0, 32'h0000_00FC, 0);
        tbl[7]  = mk(0, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_0100, 0, 32'h0000_0100, 0);
        tbl[8]  = mk(0, 1, 16'hFFFE, 1, 26'h0000008, 0, 32'h0,         0, 32'h0000_0020, 0);
        tbl[9]  = mk(0, 1, 16'h0004, 1, 26'h0000001, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0);
        tbl[10] = mk(0, 0, 16'h0000, 0, 26'h0,       0, 32'h0,         0, 32'h0000_0000, 0);
        tbl[11] = mk(0, 0, 16'h0000, 0, 26'h0,       1, 32'h0000_2000, 0, 32'h0000_2000, 0);
        tbl[12] = mk(1, 0, 16'h0000, 1, 26'h0000040, 1, 32'h0000_2002, 0, 32'h0000_2000, 1);

        do_reset();
        for (int i = 0; i < 13; i++) begin
            run_slot(tbl[i]);
            chk("tbl_pc", pc, tbl[i].exp_pc);
            chk("tbl_halt", {31'd0, halted}, {31'd0, tbl[i].exp_halt});
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("halted_no_req", {31'd0, imem_req}, 32'd0);
            chk("halted_pc_frozen", pc, 32'h0000_2000);
        end
        chk("halted_misalign_sticky", {31'd0, misalign_err}, 32'd1);

        // halt request freezes pc and stops fetching
        do_reset();
        run_slot(mk(0, 1, 16'h0010, 1, 26'h5, 0, 32'h0, 1, 32'h0, 1));
        @(posedge clk); #1;
        chk("halt_no_req", {31'd0, imem_req}, 32'd0);
        chk("halt_no_misalign", {31'd0, misalign_err}, 32'd0);

        // fetch timeout: never acknowledge
        do_reset();
        n = 0;
        for (int i = 0; i < 10 && !halted; i++) begin
            if (imem_req) n++;
            @(posedge clk); #1;
        end
        chk("timeout_fetch_cycles", 32'(n), 32'd3);
        chk("timeout_flag", {31'd0, fetch_timeout}, 32'd1);
        chk("timeout_halted", {31'd0, halted}, 32'd1);
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("timeout_ack_ignored", {31'd0, instr_valid}, 32'd0);
        chk("timeout_pc_frozen", pc, 32'd0);

        // reset asserted in the middle of a fetch after the pc has moved
        do_reset();
        run_slot(mk(0, 0, 16'h0, 1, 26'h0000050, 0, 32'h0, 0, 32'h140, 0));
        chk("midfetch_pre_req", {31'd0, imem_req}, 32'd1);
        chk("midfetch_pre_addr", imem_addr, 32'h140);
        do_reset();
        run_slot(mk(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 32'h4, 0));
        chk("midfetch_restart_pc", pc, 32'h4);

`ifdef REDIRECT_CNT_EN
        do_reset();
        run_slot(mk(0, 0, 16'h0, 1, 26'h10, 0, 32'h0, 0, 32'h40, 0));
        run_slot(mk(0, 0, 16'h0, 0, 26'h0,  0, 32'h0, 0, 32'h44, 0));
        run_slot(mk(0, 1, 16'h0, 0, 26'h0,  0, 32'h0, 0, 32'h48, 0));
        run_slot(mk(0, 0, 16'h0, 0, 26'h0,  0, 32'h0, 0, 32'h4C, 0));
        run_slot(mk(0, 0, 16'h0, 1, 26'h20, 0, 32'h0, 0, 32'h80, 0));
        run_slot(mk(0, 0, 16'h0, 0, 26'h0,  0, 32'h0, 0, 32'h84, 0));
        chk("redirect_cnt_three", {16'd0, redirect_cnt}, 32'd3);
`endif

        // randomized slots against the reference model
        do_reset();
        for (int i = 0; i < 80; i++) begin
            v.delay = $urandom_range(0, 2);
            v.h     = ($urandom_range(0, 99) < 3);
            v.jr    = ($urandom_range(0, 7) == 0);
            v.jt    = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) v.jt[0] = 1'b1;
            v.j     = ($urandom_range(0, 3) == 0);
            v.idx   = 26'($urandom);
            v.br    = ($urandom_range(0, 2) == 0);
            v.off   = 16'($urandom);
            v.exp_pc = 32'd0;
            v.exp_halt = 1'b0;
            run_slot(v);
            if (m_halt) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the core.
- Requests a fetch from instruction memory, waits for the acknowledge, then presents one decode/execute slot.
- In that slot it samples redirect requests and selects the next PC: sequential, branch, J-type jump, or register jump.
- Builds the jump target as {pc_plus4[31:28], jump_index, 2'b00}, i.e. the 26-bit index shifted left by two, and the branch target as pc_plus4 + (sign-extended offset << 2).

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- MAX_WAIT, 15, fetch-wait cycles before fetch_timeout is raised. Range 1..255.

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  asynchronous, active-high.
- imem_req  output  1  fetch request; held until imem_ack.
- imem_addr  output  32  fetch address; equals pc while imem_req=1.
- imem_ack  input  1  fetch complete; only meaningful while imem_req=1.
- instr_valid  output  1  one-cycle pulse marking the decode/execute slot.
- branch_taken  input  1  conditional branch resolved taken; sampled only when instr_valid=1.
- branch_offset  input  16  signed word offset.
- jump  input  1  J-type jump.
- jump_index  input  26  instruction index field.
- jr  input  1  register jump.
- jr_target  input  32  register value.
- halt  input  1  stop fetching.
- pc  output  32  current PC.
- pc_plus4  output  32  pc + 4, wrapping modulo 2^32.
- halted  output  1  sequencer is in HALTED.
- misalign_err  output  1  sticky; jr_target[1:0] != 0.
- fetch_timeout  output  1  sticky; wait exceeded MAX_WAIT.

Behaviour:
- Reset (asynchronous, any state, including mid-fetch):
  - pc=RESET_PC and state=BOOT.
  - imem_req=0, instr_valid=0, halted=0, misalign_err=0, fetch_timeout=0.
  - Wait counter cleared.
- States:
  - BOOT: exactly one cycle, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc, wait counter increments each cycle.
    - imem_ack=1 → EXEC and the counter clears.
    - Counter reaches MAX_WAIT with no ack → fetch_timeout=1, state=HALTED.
  - EXEC: instr_valid=1 for this single cycle; imem_req=0; redirect inputs are sampled. Next-PC priority:
    - halt → HALTED, pc unchanged.
    - jr → if jr_target[1:0]!=0: misalign_err=1, HALTED, pc unchanged. Otherwise pc=jr_target.
    - jump → pc={pc_plus4[31:28], jump_index, 2'b00}.
    - branch_taken → pc=pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00}; 32-bit wrap, no overflow flag.
    - none → pc=pc_plus4.
    - Every case except halt and a misaligned jr then goes to FETCH.
  - HALTED: terminal until reset. imem_req=0, instr_valid=0, pc frozen.
- Timing and protocol:
  - Minimum fetch-to-fetch period is 2 cycles (FETCH with immediate ack, then EXEC).
  - Redirect inputs are ignored outside EXEC.
  - Simultaneous jump+branch_taken (or jr+jump) resolves by the priority above. No error is raised.
  - imem_ack outside FETCH is ignored.
  - imem_addr is 0 when imem_req=0.
  - pc_plus4 at 32'hFFFF_FFFC wraps to 32'h0000_0000.

Optional Feature:
- Macro REDIRECT_CNT_EN.
- Defined:
  - Adds output redirect_cnt[15:0].
  - Reset value 0.
  - Increments in EXEC whenever the next PC is not pc_plus4. A jump/branch whose target equals pc_plus4 still counts.
  - Saturates at 16'hFFFF.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package pc_seq_pkg holds:
  - state enum {BOOT, FETCH, EXEC, HALTED}.
  - Next-PC select enum {SEL_SEQ, SEL_BR, SEL_J, SEL_JR}.
  - Constants WORD_BYTES=4 and PC_W=32.
- One combinational sub-module, jump_target_gen: inputs pc_plus4, jump_index, branch_offset; outputs j_target and br_target.
- The FSM, wait counter and PC register stay in pc_sequencer.

Test Plan:
- Reset then sequential: RESET_PC=0, ack on the first FETCH cycle, no redirects for 3 slots → imem_addr sequence 0, 4, 8, 12; instr_valid every 2nd cycle.
- Jump: pc=32'h4000_0010, EXEC with jump=1, jump_index=26'h0000100 → next imem_addr=32'h4000_0400.
- Branch backward with priority: pc=0x100, branch_taken=1, branch_offset=16'hFFFE, jump=0 → pc=0xFC. Same slot with jump=1, jump_index=26'h8 → pc=0x20 (jump wins).
- Register jump: jr=1, jr_target=0x2000 → pc=0x2000. A later slot with jr_target=0x2002 → misalign_err=1, halted=1, pc stays 0x2000, no further imem_req.
- Timeout and reset mid-fetch: MAX_WAIT=3, never ack → fetch_timeout=1 after 3 FETCH cycles. Separately, assert reset during FETCH → imem_req drops with no clock edge; after release, the first fetch is at RESET_PC.
- REDIRECT_CNT_EN defined: 2 jumps, 1 taken branch, 3 sequential slots → redirect_cnt=3. Preloading near saturation and forcing more redirects → counter holds at 16'hFFFF.
